// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared modulus, coefficient and requester-id types
//
// Purpose : constants and types shared by mod_multiplier and mul_arbiter.
// Ports   : none (package).
//   Q          modulus 3329
//   COEF_W     coefficient width (12)
//   ID_W       requester index width (3, covers up to 8 requesters)
//   coef_t     12-bit coefficient
//   BARRETT_*  reduction constants used by mod_multiplier

package ntt_pkg;

    localparam int Q      = 3329;
    localparam int COEF_W = 12;
    localparam int ID_W   = 3;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [ID_W-1:0]   id_t;

    // m = floor(2^k / Q); with k = 24 the estimate covers every 12x12 product.
    localparam int BARRETT_K = 24;
    localparam int BARRETT_M = 5039;

    function automatic logic coef_in_range(input coef_t v);
        return v < COEF_W'(Q);
    endfunction

endpackage

// File: rtl/mod_multiplier.sv
// rtl/mod_multiplier.sv - combinational (a*b) mod 3329 using Barrett reduction
//
// Purpose : modular product of two 12-bit coefficients.
// Ports   :
//   a  in   12  operand A (any 12-bit value)
//   b  in   12  operand B (any 12-bit value)
//   y  out  12  (a*b) mod Q, always 0..Q-1

module mod_multiplier
    import ntt_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [COEF_W-1:0] y
);

    localparam logic [13:0] Q14 = 14'(Q);

    logic [23:0] prod;
    logic [12:0] q_est;
    logic [23:0] q_times;
    logic [13:0] r0;
    logic [13:0] r1;
    logic [13:0] r2;

    assign prod = {12'b0, a} * {12'b0, b};

    // The quotient estimate is low by at most 2, so the remainder is below 3Q
    // and two conditional subtractions finish the reduction.
    assign q_est   = 13'((37'(prod) * 37'(BARRETT_M)) >> BARRETT_K);
    assign q_times = {11'b0, q_est} * 24'(Q);
    assign r0      = 14'(prod - q_times);
    assign r1      = (r0 >= Q14) ? (r0 - Q14) : r0;
    assign r2      = (r1 >= Q14) ? (r1 - Q14) : r1;
    assign y       = 12'(r2);

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one modular multiplier
//
// Purpose : NUM_REQ requesters offer operand pairs; one is granted per cycle
//           in round-robin order, its product mod Q is registered with the
//           requester index.
// Build   : define MUL_ARB_RANGE_CHECK_EN to flag operands >= Q (res_err=1,
//           res_y=0); otherwise res_err is tied 0.
// Ports   :
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous active-high reset
//   req_valid  in   NUM_REQ       per-requester operand pair valid
//   req_ready  out  NUM_REQ       per-requester grant, one-hot or zero
//   req_a      in   12*NUM_REQ    packed operand A, requester i at [12i+11:12i]
//   req_b      in   12*NUM_REQ    packed operand B, same packing
//   res_valid  out  1             result register holds a product
//   res_ready  in   1             downstream consumes the result
//   res_y      out  12            registered (a*b) mod Q
//   res_id     out  3             requester that produced res_y
//   res_err    out  1             operand range error

module mul_arbiter
    import ntt_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [COEF_W*NUM_REQ-1:0] req_a,
    input  logic [COEF_W*NUM_REQ-1:0] req_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [COEF_W-1:0]         res_y,
    output logic [ID_W-1:0]           res_id,
    output logic                      res_err
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_next;
    logic              can_accept;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic              fire;
    logic [COEF_W-1:0] a_sel;
    logic [COEF_W-1:0] b_sel;
    logic [COEF_W-1:0] mul_y;
    logic [COEF_W-1:0] y_next;

    assign can_accept = !res_valid || res_ready;

    // Round-robin as two priority searches: lowest valid index at or above ptr
    // wins; failing that, the lowest valid index overall (the wrap-around).
    // Scanning downward lets the last overwrite be the lowest index.
    always_comb begin
        logic          hi_found;
        logic [ID_W-1:0] hi_id;
        logic [ID_W-1:0] lo_id;
        hi_found    = 1'b0;
        hi_id       = '0;
        lo_id       = '0;
        grant_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                lo_id       = ID_W'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        grant_id = hi_found ? hi_id : lo_id;
    end

    assign fire = grant_found && can_accept && !rst;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                req_ready[i] = fire;
                a_sel        = req_a[COEF_W*i +: COEF_W];
                b_sel        = req_b[COEF_W*i +: COEF_W];
            end
        end
    end

    assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    mod_multiplier u_mod_multiplier (
        .a (a_sel),
        .b (b_sel),
        .y (mul_y)
    );

`ifdef MUL_ARB_RANGE_CHECK_EN
    logic range_bad;

    assign range_bad = !coef_in_range(a_sel) || !coef_in_range(b_sel);
    assign y_next    = range_bad ? '0 : mul_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err <= 1'b0;
        end else if (fire) begin
            res_err <= range_bad;
        end
    end
`else
    assign y_next  = mul_y;
    assign res_err = 1'b0;
`endif

    // A new transfer overwrites the result even while it is being consumed,
    // keeping one result per cycle under continuous res_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_id    <= '0;
            ptr       <= '0;
        end else if (fire) begin
            res_valid <= 1'b1;
            res_y     <= y_next;
            res_id    <= grant_id;
            ptr       <= ptr_next;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter

module tb_mul_arbiter;
    import ntt_pkg::*;

    localparam int N = 4;
`ifdef MUL_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [12*N-1:0]   req_a;
    logic [12*N-1:0]   req_b;
    logic              res_valid;
    logic              res_ready;
    logic [11:0]       res_y;
    logic [2:0]        res_id;
    logic              res_err;

    always #5 clk = ~clk;

    mul_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_id    (res_id),
        .res_err   (res_err)
    );

    typedef struct {
        int y;
        int id;
        int err;
    } exp_t;

    typedef struct {
        int id;
        int a;
        int b;
        int y;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t pend[N];
    int   grants[$];
    vec_t tab[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int y, input int id, input int err);
        exp_t e;
        e.y   = y;
        e.id  = id;
        e.err = err;
        return e;
    endfunction

    function automatic exp_t model(input int a, input int b, input int id);
        if (RC && (a >= 3329 || b >= 3329))
            return mk(0, id, 1);
        return mk((a * b) % 3329, id, 0);
    endfunction

    task automatic set_req(input int i, input int a, input int b, input exp_t e);
        req_a[12*i +: 12] = 12'(a);
        req_b[12*i +: 12] = 12'(b);
        pend[i]           = e;
        req_valid[i]      = 1'b1;
    endtask

    // One clock: record grants at the falling edge, drop granted requests
    // just after the rising edge that performs the transfer.
    task automatic cycle();
        logic [N-1:0] g;
        @(negedge clk);
        g = req_valid & req_ready;
        check("ready_onehot", ($countones(req_ready) > 1) ? 1 : 0, 0);
        check("ready_without_valid", int'(req_ready & ~req_valid), 0);
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                exp_q.push_back(pend[i]);
                grants.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g;
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (req_valid != '0 && k < max_cycles) begin
            cycle();
            k++;
        end
        if (req_valid != '0)
            check("grant_timeout", int'(req_valid), 0);
    endtask

    // Result scoreboard: each consumed result is matched against the oldest
    // expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_y", int'(res_y), e.y);
                check("res_id", int'(res_id), e.id);
                check("res_err", int'(res_err), e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        tab[0] = '{1, 3328, 3328, 1};
        tab[1] = '{2, 17, 17, 289};
        tab[2] = '{0, 100, 100, 13};
        tab[3] = '{3, 3328, 2, 3327};
        tab[4] = '{1, 1000, 1000, 1300};
        tab[5] = '{2, 2, 1665, 1};
        tab[6] = '{0, 3000, 3000, 1713};
        tab[7] = '{3, 1665, 1665, 2497};
        tab[8] = '{1, 0, 3328, 0};
        tab[9] = '{2, 475, 7, 3325};

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // All four valid while still in reset.
        for (int i = 0; i < N; i++)
            set_req(i, 17, 17, mk(289, i, 0));
        #3;
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_y", int'(res_y), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_res_err", int'(res_err), 0);
        check("rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (4) cycle();
        check("rr_grant_count", grants.size(), 4);
        for (int i = 0; i < N; i++)
            if (i < grants.size())
                check("rr_grant_order", grants[i], i);
        grants.delete();

        // Table of single requests with hand-computed products.
        for (int t = 0; t < 10; t++) begin
            set_req(tab[t].id, tab[t].a, tab[t].b, mk(tab[t].y, tab[t].id, 0));
            drain(8);
        end
        grants.delete();

        // Wrap: grant 3, then 0 and 3 together must serve 0 first.
        set_req(3, 5, 6, model(5, 6, 3));
        drain(4);
        grants.delete();
        set_req(0, 11, 13, model(11, 13, 0));
        set_req(3, 3328, 3327, model(3328, 3327, 3));
        drain(4);
        check("wrap_count", grants.size(), 2);
        if (grants.size() == 2) begin
            check("wrap_first", grants[0], 0);
            check("wrap_second", grants[1], 3);
        end
        grants.delete();

        // Backpressure: result held, no grants, then immediate grant on release.
        set_req(0, 100, 100, mk(13, 0, 0));
        drain(4);
        res_ready = 1'b0;
        set_req(1, 7, 9, model(7, 9, 1));
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready", int'(req_ready), 0);
            check("bp_res_valid", int'(res_valid), 1);
            check("bp_hold_y", int'(res_y), 13);
            check("bp_hold_id", int'(res_id), 0);
            @(posedge clk);
        end
        #1;
        res_ready = 1'b1;
        cycle();
        check("bp_grants", grants.size(), 2);
        if (grants.size() == 2)
            check("bp_grant_id", grants[1], 1);
        grants.delete();

        // Reset while a result is stalled; pointer would otherwise favour 3.
        set_req(2, 9, 9, model(9, 9, 2));
        drain(4);
        res_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", int'(res_valid), 0);
        check("rst_async_y", int'(res_y), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        grants.delete();
        set_req(1, 21, 22, model(21, 22, 1));
        set_req(3, 23, 24, model(23, 24, 3));
        drain(4);
        check("post_rst_count", grants.size(), 2);
        if (grants.size() == 2) begin
            check("post_rst_first", grants[0], 1);
            check("post_rst_second", grants[1], 3);
        end

        // Operand range boundary.
        set_req(0, 3329, 1, model(3329, 1, 0));
        drain(4);
        set_req(0, 0, 3328, model(0, 3328, 0));
        drain(4);
        set_req(2, 4095, 4095, model(4095, 4095, 2));
        drain(4);
        set_req(1, 3328, 4000, model(3328, 4000, 1));
        drain(4);

        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
